dobby_ext_slave: RTL and testbench
==================================

Name: dobby_ext_slave

Overview:
- Bus slave directly downstream of the Dobby core's external bus port (o_bus_en/o_bus_wen/o_bus_addr/o_bus_size/o_store_data).
- Returns i_bus_ready/i_load_data and drives the core's i_intr inputs.
- Contains a word-organised external SRAM with programmable wait states and byte-lane handling, plus a memory-mapped timer.
- Reports bus errors (misaligned or unmapped accesses) as an interrupt.

Parameters:
- WAIT_STATES, 1, extra cycles between request capture and the ready pulse (0..15).
- MEM_WORDS, 4096, SRAM depth in 32-bit words, mapped from byte address 0x0000.
- TIMER_BASE, 8'hFF, value of addr[15:8] that selects the timer register page.

Ports:
- clk  in  1  core clock.
- a_reset_l  in  1  asynchronous active-low reset.
- i_bus_en  in  1  request valid; held high by the master until it sees o_bus_ready.
- i_bus_wen  in  1  1 = store, 0 = load.
- i_bus_addr  in  16  byte address.
- i_bus_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- i_store_data  in  32  store data, right-aligned.
- o_bus_ready  out  1  one-cycle completion pulse.
- o_load_data  out  32  load data, right-aligned, zero-extended; valid only while o_bus_ready is high.
- o_intr  out  2  [0] timer interrupt, [1] bus-error interrupt; level signals.
- i_intr_ack  in  2  per-line acknowledge from the core.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on a_reset_l. All registers clear immediately on reset assertion.
- Reset values:
  - o_bus_ready = 0, o_load_data = 0, o_intr = 0.
  - FSM = IDLE.
  - CTRL, COUNT and STATUS = 0; COMPARE = 32'hFFFF_FFFF.
  - SRAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If i_bus_en = 1, capture addr/wen/size/data and load the wait counter with WAIT_STATES.
  - Next state is WAIT, or RESP when WAIT_STATES = 0.
- WAIT:
  - Decrement the counter.
  - When the counter reaches 1, perform the access (SRAM read/write or register update); next state is RESP.
- RESP:
  - o_bus_ready = 1 for exactly one cycle, with o_load_data.
  - Next state is IDLE.
  - The master drops i_bus_en or presents a new request in the cycle after ready; a new request is sampled in IDLE, giving one bubble cycle.
- Latency: ready is asserted WAIT_STATES+1 cycles after the cycle in which i_bus_en is sampled in IDLE.
- Input changes after capture are ignored. Reset mid-transaction aborts it with no ready and no partial write.
- Address decode:
  - addr[15:2] < MEM_WORDS selects SRAM.
  - addr[15:8] = TIMER_BASE selects timer registers (word access only).
  - Anything else is unmapped.
- Errors:
  - Conditions: half access with addr[0] = 1, word access with addr[1:0] != 0, size 11, unmapped address, or non-word timer access.
  - Response: ready still pulses with o_load_data = 0, no state changes, and STATUS[1] is set.
- SRAM byte lanes:
  - Byte store writes lane addr[1:0] with data[7:0].
  - Half store writes lanes {addr[1],0} and {addr[1],1} with data[15:0].
  - Word store writes all four lanes.
  - Loads return the selected byte or half in [7:0] or [15:0], upper bits zero.
- Timer registers (offset = addr[7:0]):
  - 0x00 CTRL: [0] enable, [1] irq enable, [2] auto-reload.
  - 0x04 COUNT.
  - 0x08 COMPARE.
  - 0x0C STATUS: [0] timer pending, [1] bus error; write-1-to-clear.
  - Other offsets are an error.
- Counter:
  - COUNT increments by 1 per cycle while CTRL[0] = 1 and wraps at 2^32.
  - When COUNT == COMPARE and enabled, STATUS[0] is set. With auto-reload, the next COUNT is 0; otherwise it keeps incrementing.
  - A bus write to COUNT overrides the increment in that cycle.
- Interrupts:
  - o_intr[0] = STATUS[0] & CTRL[1]; o_intr[1] = STATUS[1].
  - i_intr_ack[n] clears STATUS[n].
- Simultaneous events:
  - Set wins over ack and W1C clear in the same cycle.
  - A COMPARE write takes effect for the next cycle's comparison.

Test Plan:
- Word store then load (WAIT_STATES = 1): store 0xCAFE_F00D to 0x0010, then load 0x0010 -> ready 2 cycles after each request is sampled; load returns 0xCAFE_F00D.
- Byte/half lanes: store byte 0xAB to 0x0013, then load word 0x0010 -> 0xABFE_F00D. Load half 0x0012 -> 0x0000_ABFE. Load byte 0x0011 -> 0x0000_00F0.
- Misaligned/unmapped: word load at 0x0012 -> ready with data 0, o_intr[1] = 1, SRAM unchanged. Pulse i_intr_ack[1] -> o_intr[1] = 0 the next cycle.
- Timer: write COMPARE = 5, then CTRL = 0x7 -> o_intr[0] rises when COUNT == 5 and COUNT reloads to 0. Ack clears it; it fires again 6 cycles later. An ack in the same cycle as a match leaves it pending.
- Reset mid-access: assert a_reset_l = 0 during WAIT of a store to 0x0020 -> no ready; SRAM word unchanged; all outputs 0; COMPARE reads 0xFFFF_FFFF after reset.
- WAIT_STATES = 0 back-to-back: two loads with i_bus_en held high -> ready one cycle after each capture, with one idle bubble between them.

Source files
------------

// File: rtl/dobby_ext_slave.sv
// dobby_ext_slave: external bus slave with wait-stated byte-lane SRAM, memory-mapped timer and bus-error interrupt
module dobby_ext_slave #(
  parameter int         WAIT_STATES = 1,
  parameter int         MEM_WORDS   = 4096,
  parameter logic [7:0] TIMER_BASE  = 8'hFF
) (
  input  logic        clk,
  input  logic        a_reset_l,
  input  logic        i_bus_en,
  input  logic        i_bus_wen,
  input  logic [15:0] i_bus_addr,
  input  logic [1:0]  i_bus_size,
  input  logic [31:0] i_store_data,
  output logic        o_bus_ready,
  output logic [31:0] o_load_data,
  output logic [1:0]  o_intr,
  input  logic [1:0]  i_intr_ack
);
  localparam int         AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_wen;
  logic [1:0]  r_size;
  logic [15:0] r_addr;
  logic [31:0] r_data;
  logic [2:0]  r_ctrl;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic [1:0]  r_status;
  logic [31:0] r_mem [MEM_WORDS];

  logic        w_idle, w_access, w_wen, w_sram, w_timer, w_treg_ok, w_err, w_ok;
  logic        w_mem_we, w_twr, w_wr_ctrl, w_wr_cnt, w_wr_cmp, w_wr_sts, w_match;
  logic [1:0]  w_size;
  logic [15:0] w_addr;
  logic [7:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_data, w_wlane, w_word, w_shift, w_sram_rd, w_treg_rd, w_rd;

  // With zero wait states the access happens straight from the live bus inputs in IDLE
  assign w_idle    = r_state == S_IDLE;
  assign w_access  = (w_idle && i_bus_en && WS == 4'd0) || (r_state == S_WAIT && r_cnt == 4'd1);
  assign w_wen     = w_idle ? i_bus_wen    : r_wen;
  assign w_size    = w_idle ? i_bus_size   : r_size;
  assign w_addr    = w_idle ? i_bus_addr   : r_addr;
  assign w_data    = w_idle ? i_store_data : r_data;
  assign w_off     = w_addr[7:0];

  // SRAM takes priority over the timer page if the two ever overlap
  assign w_sram    = 32'(w_addr[15:2]) < MEM_WORDS;
  assign w_timer   = !w_sram && w_addr[15:8] == TIMER_BASE;
  assign w_treg_ok = w_off[7:4] == 4'd0 && w_off[1:0] == 2'd0;
  assign w_err     = w_size == 2'b11
                  || (w_size == 2'b01 && w_addr[0])
                  || (w_size == 2'b10 && w_addr[1:0] != 2'b00)
                  || (!w_sram && !w_timer)
                  || (w_timer && (w_size != 2'b10 || !w_treg_ok));
  assign w_ok      = w_access && !w_err;

  // Byte lanes and lane-replicated write data so each lane picks its own slice
  assign w_be      = w_size == 2'b00 ? 4'b0001 << w_addr[1:0]
                   : w_size == 2'b01 ? (w_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign w_wlane   = w_size == 2'b00 ? {4{w_data[7:0]}}
                   : w_size == 2'b01 ? {2{w_data[15:0]}} : w_data;
  assign w_mem_we  = w_ok && w_sram && w_wen && a_reset_l;

  assign w_word    = r_mem[w_addr[AW+1:2]];
  assign w_shift   = w_word >> {w_addr[1:0], 3'b000};
  assign w_sram_rd = w_size == 2'b00 ? {24'd0, w_shift[7:0]}
                   : w_size == 2'b01 ? {16'd0, w_shift[15:0]} : w_word;
  assign w_treg_rd = w_off[3:2] == 2'd0 ? {29'd0, r_ctrl}
                   : w_off[3:2] == 2'd1 ? r_count
                   : w_off[3:2] == 2'd2 ? r_compare : {30'd0, r_status};
  assign w_rd      = (w_err || w_wen) ? 32'd0 : w_sram ? w_sram_rd : w_treg_rd;

  assign w_twr     = w_ok && w_timer && w_wen;
  assign w_wr_ctrl = w_twr && w_off[3:2] == 2'd0;
  assign w_wr_cnt  = w_twr && w_off[3:2] == 2'd1;
  assign w_wr_cmp  = w_twr && w_off[3:2] == 2'd2;
  assign w_wr_sts  = w_twr && w_off[3:2] == 2'd3;
  assign w_match   = r_ctrl[0] && r_count == r_compare;

  assign o_intr    = {r_status[1], r_status[0] & r_ctrl[1]};

  // Request capture, wait-state countdown and registered ready/data response
  always_ff @(posedge clk or negedge a_reset_l) begin
    if (!a_reset_l) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_wen       <= 1'b0;
      r_size      <= 2'd0;
      r_addr      <= 16'd0;
      r_data      <= 32'd0;
      o_bus_ready <= 1'b0;
      o_load_data <= 32'd0;
    end else begin
      o_bus_ready <= w_access;
      o_load_data <= w_access ? w_rd : 32'd0;
      case (r_state)
        S_IDLE: if (i_bus_en) begin
          r_wen   <= i_bus_wen;
          r_size  <= i_bus_size;
          r_addr  <= i_bus_addr;
          r_data  <= i_store_data;
          r_cnt   <= WS;
          r_state <= (WS == 4'd0) ? S_RESP : S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= S_RESP;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Timer registers; hardware set of a STATUS bit wins over ack and W1C clear
  always_ff @(posedge clk or negedge a_reset_l) begin
    if (!a_reset_l) begin
      r_ctrl    <= 3'd0;
      r_count   <= 32'd0;
      r_compare <= 32'hFFFF_FFFF;
      r_status  <= 2'd0;
    end else begin
      if (w_wr_ctrl) r_ctrl <= w_data[2:0];
      if (w_wr_cmp) r_compare <= w_data;
      r_count     <= w_wr_cnt ? w_data : !r_ctrl[0] ? r_count
                   : (w_match && r_ctrl[2]) ? 32'd0 : r_count + 32'd1;
      r_status[0] <= w_match | (r_status[0] & ~i_intr_ack[0] & ~(w_wr_sts & w_data[0]));
      r_status[1] <= (w_access & w_err) | (r_status[1] & ~i_intr_ack[1] & ~(w_wr_sts & w_data[1]));
    end
  end

  // SRAM array is not reset; writes only on a legal store access
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (w_mem_we && w_be[i]) r_mem[w_addr[AW+1:2]][8*i +: 8] <= w_wlane[8*i +: 8];
  end
endmodule

// File: tb/tb_dobby_ext_slave.sv
// tb_dobby_ext_slave: directed self-checking bench for dobby_ext_slave (WAIT_STATES 1 and 0)
module tb_dobby_ext_slave;
  logic        clk = 1'b0;
  logic        rst_l, en, wen;
  logic [1:0]  sz, ack;
  logic [15:0] addr;
  logic [31:0] wd, rd;
  logic        rdy1, rdy0;
  logic [31:0] ld1, ld0;
  logic [1:0]  it1, it0;
  int          vec = 0;
  int          miss = 0;

  always #5 clk = ~clk;

  dobby_ext_slave #(.WAIT_STATES(1)) u1 (
    .clk(clk), .a_reset_l(rst_l), .i_bus_en(en), .i_bus_wen(wen), .i_bus_addr(addr),
    .i_bus_size(sz), .i_store_data(wd), .o_bus_ready(rdy1), .o_load_data(ld1),
    .o_intr(it1), .i_intr_ack(ack)
  );

  dobby_ext_slave #(.WAIT_STATES(0)) u0 (
    .clk(clk), .a_reset_l(rst_l), .i_bus_en(en), .i_bus_wen(wen), .i_bus_addr(addr),
    .i_bus_size(sz), .i_store_data(wd), .o_bus_ready(rdy0), .o_load_data(ld0),
    .o_intr(it0), .i_intr_ack(ack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus(input string tag, input logic w, input logic [1:0] s, input logic [15:0] a,
                     input logic [31:0] d, output logic [31:0] r);
    int n;
    en = 1'b1; wen = w; sz = s; addr = a; wd = d;
    n = 0;
    do begin tick(); n++; end while (!rdy1 && n < 20);
    r = ld1;
    chk({tag, " latency"}, n, 2);
    en = 1'b0;
    tick();
    chk({tag, " pulse"}, {31'd0, rdy1}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_l = 1'b0; en = 1'b0; wen = 1'b0; sz = 2'd0; addr = 16'd0; wd = 32'd0; ack = 2'd0;
    tick(); tick();
    chk("reset ready", {31'd0, rdy1}, 0);
    chk("reset data", ld1, 0);
    chk("reset intr", {30'd0, it1}, 0);
    chk("reset ready ws0", {31'd0, rdy0}, 0);
    rst_l = 1'b1;
    tick();
    bus("st word", 1'b1, 2'd2, 16'h0010, 32'hCAFE_F00D, rd);
    bus("ld word", 1'b0, 2'd2, 16'h0010, 32'd0, rd);
    chk("ld word data", rd, 32'hCAFE_F00D);
    bus("st byte", 1'b1, 2'd0, 16'h0013, 32'h0000_00AB, rd);
    bus("ld word2", 1'b0, 2'd2, 16'h0010, 32'd0, rd);
    chk("ld word2 data", rd, 32'hABFE_F00D);
    bus("ld half", 1'b0, 2'd1, 16'h0012, 32'd0, rd);
    chk("ld half data", rd, 32'h0000_ABFE);
    bus("ld byte", 1'b0, 2'd0, 16'h0011, 32'd0, rd);
    chk("ld byte data", rd, 32'h0000_00F0);
    bus("st half", 1'b1, 2'd1, 16'h0012, 32'h0000_BEEF, rd);
    bus("ld word3", 1'b0, 2'd2, 16'h0010, 32'd0, rd);
    chk("ld word3 data", rd, 32'hBEEF_F00D);
    bus("misalign ld", 1'b0, 2'd2, 16'h0012, 32'd0, rd);
    chk("misalign ld data", rd, 0);
    chk("misalign intr", {30'd0, it1}, 2);
    bus("misalign st", 1'b1, 2'd2, 16'h0012, 32'hDEAD_BEEF, rd);
    bus("ld after err", 1'b0, 2'd2, 16'h0010, 32'd0, rd);
    chk("sram unchanged", rd, 32'hBEEF_F00D);
    ack = 2'b10;
    tick();
    ack = 2'b00;
    chk("err ack", {30'd0, it1}, 0);
    bus("unmapped", 1'b0, 2'd2, 16'h8000, 32'd0, rd);
    chk("unmapped data", rd, 0);
    chk("unmapped intr", {30'd0, it1}, 2);
    ack = 2'b10;
    tick();
    ack = 2'b00;
    bus("timer byte", 1'b0, 2'd0, 16'hFF00, 32'd0, rd);
    chk("timer byte intr", {30'd0, it1}, 2);
    bus("size11", 1'b0, 2'd3, 16'h0010, 32'd0, rd);
    chk("size11 data", rd, 0);
    ack = 2'b10;
    tick();
    ack = 2'b00;
    chk("err ack2", {30'd0, it1}, 0);
    bus("wr compare", 1'b1, 2'd2, 16'hFF08, 32'd5, rd);
    bus("wr ctrl", 1'b1, 2'd2, 16'hFF00, 32'd7, rd);
    repeat (4) tick();
    chk("timer before match", {30'd0, it1}, 0);
    tick();
    chk("timer match", {30'd0, it1}, 1);
    ack = 2'b01;
    tick();
    ack = 2'b00;
    chk("timer ack", {30'd0, it1}, 0);
    repeat (4) tick();
    chk("timer reload quiet", {30'd0, it1}, 0);
    tick();
    chk("timer refire", {30'd0, it1}, 1);
    ack = 2'b01;
    tick();
    ack = 2'b00;
    chk("timer ack2", {30'd0, it1}, 0);
    repeat (4) tick();
    ack = 2'b01;
    tick();
    ack = 2'b00;
    chk("ack vs match", {30'd0, it1}, 1);
    ack = 2'b01;
    tick();
    ack = 2'b00;
    chk("timer ack3", {30'd0, it1}, 0);
    bus("rd count", 1'b0, 2'd2, 16'hFF04, 32'd0, rd);
    chk("count value", rd, 2);
    bus("st 20", 1'b1, 2'd2, 16'h0020, 32'h1122_3344, rd);
    en = 1'b1; wen = 1'b1; sz = 2'd2; addr = 16'h0020; wd = 32'h5566_7788;
    tick();
    chk("pre-abort ready", {31'd0, rdy1}, 0);
    rst_l = 1'b0;
    #1;
    chk("abort ready", {31'd0, rdy1}, 0);
    chk("abort data", ld1, 0);
    chk("abort intr", {30'd0, it1}, 0);
    en = 1'b0;
    tick(); tick();
    chk("abort no ready", {31'd0, rdy1}, 0);
    rst_l = 1'b1;
    tick();
    bus("ld 20", 1'b0, 2'd2, 16'h0020, 32'd0, rd);
    chk("no partial write", rd, 32'h1122_3344);
    bus("rd compare", 1'b0, 2'd2, 16'hFF08, 32'd0, rd);
    chk("compare reset", rd, 32'hFFFF_FFFF);
    chk("intr after reset", {30'd0, it1}, 0);
    en = 1'b1; wen = 1'b0; sz = 2'd2; addr = 16'h0010;
    tick();
    chk("ws0 ready1", {31'd0, rdy0}, 1);
    chk("ws0 data1", ld0, 32'hBEEF_F00D);
    sz = 2'd0; addr = 16'h0013;
    tick();
    chk("ws0 bubble", {31'd0, rdy0}, 0);
    tick();
    chk("ws0 ready2", {31'd0, rdy0}, 1);
    chk("ws0 data2", ld0, 32'h0000_00BE);
    en = 1'b0;
    tick();
    chk("ws0 pulse", {31'd0, rdy0}, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
